// File: rtl/window.sv
// Sliding-window generator: buffers one raster frame, then emits one zero-padded,
// strided KERNEL_SIZE x KERNEL_SIZE window per cycle in raster order.
module window #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 5,
  parameter int unsigned IMG_HEIGHT  = 5,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned PADDING     = (KERNEL_SIZE - 1) / 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH-1:0]                     pixel_in,
  input  logic                                      pixel_valid,
  input  logic                                      frame_start,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                      window_valid
);

  localparam int unsigned OUT_W  = (IMG_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int unsigned OUT_H  = (IMG_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int unsigned NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned WIN_W  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  // Signed copies so padding offsets can go negative in the address math.
  localparam int W_I = int'(IMG_WIDTH);
  localparam int H_I = int'(IMG_HEIGHT);
  localparam int K_I = int'(KERNEL_SIZE);
  localparam int S_I = int'(STRIDE);
  localparam int P_I = int'(PADDING);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StProcess = 2'd2
  } state_e;

  state_e              current_state, current_state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]       x_window, x_window_d, cur_x;
  logic [YW-1:0]       y_window, y_window_d, cur_y;
  logic                first_q, first_d;
  logic [WIN_W-1:0]    win_q, win_d, win_c;
  logic                valid_q, valid_d;
  logic                wr_en;
  logic [DATA_WIDTH-1:0] mem_q [NPIX];
  logic [ADDR_W-1:0]   rd_addr;
  int                  rd_row, rd_col;

  assign window_out   = win_q;
  assign window_valid = valid_q;

  // Coordinates of the window being formed this cycle; x_window/y_window hold the
  // previously emitted one, so the next is derived from them (first_q marks (0,0)).
  always_comb begin
    cur_x = '0;
    cur_y = '0;
    if (!first_q) begin
      if (x_window == XW'(OUT_W - 1)) begin
        cur_y = y_window + YW'(1);
      end else begin
        cur_x = x_window + XW'(1);
        cur_y = y_window;
      end
    end
  end

  // Gather the window at (cur_x, cur_y), substituting zero outside the image.
  always_comb begin
    win_c   = '0;
    rd_row  = 0;
    rd_col  = 0;
    rd_addr = '0;
    for (int r = 0; r < K_I; r++) begin
      for (int c = 0; c < K_I; c++) begin
        rd_row = int'(cur_y) * S_I - P_I + r;
        rd_col = int'(cur_x) * S_I - P_I + c;
        if (rd_row >= 0 && rd_row < H_I && rd_col >= 0 && rd_col < W_I) begin
          rd_addr = ADDR_W'(rd_row * W_I + rd_col);
          win_c[(K_I*K_I-1-(r*K_I+c))*int'(DATA_WIDTH) +: DATA_WIDTH] = mem_q[rd_addr];
        end
      end
    end
  end

  // Next-state logic: load frame, sweep output grid, abort on frame_start.
  always_comb begin
    current_state_d = current_state;
    cnt_d           = cnt_q;
    x_window_d      = x_window;
    y_window_d      = y_window;
    first_d         = first_q;
    win_d           = win_q;
    valid_d         = 1'b0;
    wr_en           = 1'b0;
    unique case (current_state)
      StIdle: begin
        if (frame_start) begin
          current_state_d = StLoad;
          cnt_d           = '0;
        end
      end
      StLoad: begin
        if (frame_start) begin
          cnt_d = '0;
        end else if (pixel_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(NPIX - 1)) begin
            current_state_d = StProcess;
            cnt_d           = '0;
            x_window_d      = '0;
            y_window_d      = '0;
            first_d         = 1'b1;
          end
        end
      end
      StProcess: begin
        if (frame_start) begin
          current_state_d = StLoad;
          cnt_d           = '0;
          x_window_d      = '0;
          y_window_d      = '0;
          first_d         = 1'b0;
        end else begin
          win_d      = win_c;
          valid_d    = 1'b1;
          x_window_d = cur_x;
          y_window_d = cur_y;
          first_d    = 1'b0;
          if (cur_x == XW'(OUT_W - 1) && cur_y == YW'(OUT_H - 1)) begin
            current_state_d = StIdle;
          end
        end
      end
      default: current_state_d = StIdle;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= StIdle;
      cnt_q         <= '0;
      x_window      <= '0;
      y_window      <= '0;
      first_q       <= 1'b0;
      win_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      current_state <= current_state_d;
      cnt_q         <= cnt_d;
      x_window      <= x_window_d;
      y_window      <= y_window_d;
      first_q       <= first_d;
      win_q         <= win_d;
      valid_q       <= valid_d;
    end
  end

  // Frame buffer; contents survive between frames and are fully rewritten by each load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_window.sv
// Bench for window: 5x5 frames into a stride-1 and a stride-2 instance sharing inputs.
module tb_window;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        frame_start;
  logic [71:0] wo1, wo2;
  logic        wv1, wv2;

  always #5 clk = ~clk;

  window #(.STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .window_out(wo1), .window_valid(wv1)
  );

  window #(.STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .window_out(wo2), .window_valid(wv2)
  );

  typedef struct {
    logic [71:0] win;
    int          x;
    int          y;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int          frame[25];
  logic [71:0] cap1[25];
  logic [71:0] cap2[9];
  int          stb1 = 0, stb2 = 0;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] p9(input int a, input int b, input int c, input int d,
                                     input int e, input int f, input int g, input int h,
                                     input int i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  // Model: element (r,c) is image pixel (oy*s-1+r, ox*s-1+c), zero outside the 5x5 image.
  function automatic logic [71:0] model_win(input int ox, input int oy, input int s);
    logic [71:0] w;
    int row, col;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        row = oy * s - 1 + r;
        col = ox * s - 1 + c;
        if (row >= 0 && row < 5 && col >= 0 && col < 5)
          w[(8 - (r * 3 + c)) * 8 +: 8] = 8'(frame[row * 5 + col]);
      end
    end
    return w;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int s = 1; s <= 2; s++) begin
      for (int oy = 0; oy < 4 / s + 1; oy++) begin
        for (int ox = 0; ox < 4 / s + 1; ox++) begin
          e.win = model_win(ox, oy, s);
          e.x   = ox;
          e.y   = oy;
          if (s == 1) q1.push_back(e);
          else        q2.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every strobe against the model's expected raster sequence.
  always @(negedge clk) begin
    exp_t e;
    if (wv1) begin
      stb1++;
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL s1_extra_strobe: got strobe expected none");
      end else begin
        e = q1.pop_front();
        chk("s1_window", wo1, e.win);
        chk_int("s1_x", int'(dut.x_window), e.x);
        chk_int("s1_y", int'(dut.y_window), e.y);
        cap1[e.y * 5 + e.x] = wo1;
      end
    end
    if (wv2) begin
      stb2++;
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL s2_extra_strobe: got strobe expected none");
      end else begin
        e = q2.pop_front();
        chk("s2_window", wo2, e.win);
        chk_int("s2_x", int'(dut2.x_window), e.x);
        chk_int("s2_y", int'(dut2.y_window), e.y);
        cap2[e.y * 3 + e.x] = wo2;
      end
    end
  end

  // frame_start (optionally with a pixel that must be dropped), then 25 pixels.
  task automatic load_frame(input int base, input bit gaps, input bit drop);
    for (int i = 0; i < 25; i++) frame[i] = base + i;
    push_expected();
    frame_start = 1'b1;
    pixel_valid = drop;
    pixel_in    = 8'hEE;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (gaps && (i % 4 == 2)) begin
        pixel_valid = 1'b0;
        pixel_in    = 8'hAA;
        tick();
        tick();
      end
      pixel_valid = 1'b1;
      pixel_in    = 8'(base + i);
      tick();
    end
    pixel_valid = 1'b1;  // ignored in PROCESS
    pixel_in    = 8'h55;
    chk_int("latency_pre_s1", int'(wv1), 0);
    chk_int("latency_pre_s2", int'(wv2), 0);
    tick();
    pixel_valid = 1'b0;
    chk_int("latency_first_s1", int'(wv1), 1);
    chk_int("latency_first_s2", int'(wv2), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) tick();
    chk_int("done_pending_s1", q1.size(), 0);
    chk_int("done_pending_s2", q2.size(), 0);
    tick();
    tick();
    chk_int("idle_state_s1", int'(dut.current_state), 0);
    chk_int("idle_state_s2", int'(dut2.current_state), 0);
    chk_int("idle_valid_s1", int'(wv1), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    chk("reset_window", wo1, 72'd0);
    chk_int("reset_valid", int'(wv1), 0);
    chk_int("reset_state", int'(dut.current_state), 0);
    chk_int("reset_x", int'(dut.x_window), 0);
    chk_int("reset_y", int'(dut.y_window), 0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores pixel_valid.
    pixel_valid = 1'b1;
    pixel_in    = 8'h33;
    repeat (3) tick();
    pixel_valid = 1'b0;
    chk_int("idle_ignore_state", int'(dut.current_state), 0);

    // Frame 1..25, dropped pixel on the frame_start cycle.
    chk("model_pin", model_win(0, 0, 1), 72'd0);  // frame not loaded yet: all zero
    stb1 = 0;
    stb2 = 0;
    load_frame(1, 1'b0, 1'b1);
    chk("model_pin_00", model_win(0, 0, 1), p9(0, 0, 0, 0, 1, 2, 0, 6, 7));
    wait_done();
    chk_int("count_s1", stb1, 25);
    chk_int("count_s2", stb2, 9);
    chk("lit_00", cap1[0], p9(0, 0, 0, 0, 1, 2, 0, 6, 7));
    chk("lit_22", cap1[12], p9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    chk("lit_44", cap1[24], p9(19, 20, 0, 24, 25, 0, 0, 0, 0));
    chk("lit_40", cap1[4], p9(0, 0, 0, 4, 5, 0, 9, 10, 0));
    chk("lit_s2_11", cap2[4], p9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    chk("hold_s1", wo1, p9(19, 20, 0, 24, 25, 0, 0, 0, 0));
    chk("hold_s2", wo2, p9(19, 20, 0, 24, 25, 0, 0, 0, 0));

    // Different frame with pixel_valid gaps.
    stb1 = 0;
    load_frame(40, 1'b1, 1'b0);
    wait_done();
    chk_int("gaps_count", stb1, 25);

    // Abort after 10 pixels, then a full frame.
    stb1 = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'(100 + i);
      tick();
    end
    pixel_valid = 1'b0;
    load_frame(1, 1'b0, 1'b0);
    wait_done();
    chk_int("abort_count", stb1, 25);
    chk("abort_lit_22", cap1[12], p9(7, 8, 9, 12, 13, 14, 17, 18, 19));

    // Asynchronous reset in the middle of PROCESS.
    load_frame(5, 1'b0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk_int("rst_valid_s1", int'(wv1), 0);
    chk_int("rst_valid_s2", int'(wv2), 0);
    chk("rst_window", wo1, 72'd0);
    chk_int("rst_state", int'(dut.current_state), 0);
    q1.delete();
    q2.delete();
    stb1 = 0;
    stb2 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk_int("post_rst_strobes", stb1 + stb2, 0);

    // Recovery after reset.
    stb1 = 0;
    load_frame(3, 1'b0, 1'b0);
    wait_done();
    chk_int("recover_count", stb1, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
